// File: rtl/ibuf_window.sv
// Multi-lane shift-register window feeding the crossbar row drivers; data and count update one edge after a push.
// Backpressure: o_ready drops while a full window is held, and rises again one edge after i_window_ack.
module ibuf_window #(
    parameter int DATATYPE_SIZE = 8,
    parameter int DEPTH         = 10,
    parameter int CHANNELS      = 1,
    parameter int STRIDE        = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_valid,
    output logic                              o_ready,
    input  logic [CHANNELS*DATATYPE_SIZE-1:0] i_data,
    input  logic                              i_window_ack,
    input  logic                              i_slide,
    input  logic                              i_flush,
    output logic                              o_window_valid,
    output logic [$clog2(DEPTH+1)-1:0]        o_count,
    output logic [DEPTH*DATATYPE_SIZE-1:0]    o_data
);

    localparam int W  = DATATYPE_SIZE;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CHAN_C   = CW'(CHANNELS);
    localparam logic [CW-1:0] RESUME_C = CW'(DEPTH - STRIDE);
    localparam bit            CAN_SLIDE = (STRIDE < DEPTH);

    typedef enum logic {
        FILL   = 1'b0,
        WINDOW = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DEPTH*W-1:0]     data_q, data_d;
    logic [DEPTH*W-1:0]     shifted;
    logic [CW-1:0]          count_inc;

    // Lane 0 is the oldest word of a beat, so it lands deepest among the new entries.
    for (genvar k = 0; k < DEPTH; k++) begin : g_shift
        if (k < CHANNELS) begin : g_new
            assign shifted[k*W +: W] = i_data[(CHANNELS-1-k)*W +: W];
        end else begin : g_old
            assign shifted[k*W +: W] = data_q[(k-CHANNELS)*W +: W];
        end
    end

    assign count_inc = count_q + CHAN_C;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        if (i_flush) begin
            state_d = FILL;
            count_d = '0;
            data_d  = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (i_valid) begin
                        data_d  = shifted;
                        count_d = count_inc;
                        if (count_inc == DEPTH_C) begin
                            state_d = WINDOW;
                        end
                    end
                end
                WINDOW: begin
                    if (i_window_ack) begin
                        state_d = FILL;
                        // A slide keeps the newest entries as the head of the next window.
                        count_d = (i_slide && CAN_SLIDE) ? RESUME_C : '0;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign o_ready        = (state_q == FILL);
    assign o_window_valid = (state_q == WINDOW);
    assign o_count        = count_q;
    assign o_data         = data_q;

endmodule

// File: tb/tb_ibuf_window.sv
// Bench for ibuf_window: a default 10x8b single-lane instance and a 4-entry two-lane instance.
module tb_ibuf_window;

    localparam int W  = 8;
    localparam int D  = 10;
    localparam int C  = 1;
    localparam int S  = 2;
    localparam int CW = $clog2(D + 1);

    localparam int D2  = 4;
    localparam int C2  = 2;
    localparam int S2  = 2;
    localparam int CW2 = $clog2(D2 + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic              a_valid, a_ready, a_ack, a_slide, a_flush, a_wv;
    logic [C*W-1:0]    a_data;
    logic [CW-1:0]     a_count;
    logic [D*W-1:0]    a_odata;

    logic              b_valid, b_ready, b_ack, b_slide, b_flush, b_wv;
    logic [C2*W-1:0]   b_data;
    logic [CW2-1:0]    b_count;
    logic [D2*W-1:0]   b_odata;

    int checks = 0;
    int errors = 0;

    logic [D*W-1:0]  exp_q[$];
    logic [D2*W-1:0] expb_q[$];
    logic [D*W-1:0]  exp_win;
    logic [D2*W-1:0] expb_win;

    logic [W-1:0] m_ent[D];
    int           m_cnt;
    bit           m_win;

    ibuf_window #(.DATATYPE_SIZE(W), .DEPTH(D), .CHANNELS(C), .STRIDE(S)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready), .i_data(a_data),
        .i_window_ack(a_ack), .i_slide(a_slide), .i_flush(a_flush),
        .o_window_valid(a_wv), .o_count(a_count), .o_data(a_odata)
    );

    ibuf_window #(.DATATYPE_SIZE(W), .DEPTH(D2), .CHANNELS(C2), .STRIDE(S2)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready), .i_data(b_data),
        .i_window_ack(b_ack), .i_slide(b_slide), .i_flush(b_flush),
        .o_window_valid(b_wv), .o_count(b_count), .o_data(b_odata)
    );

    always #5 clk = ~clk;

    function automatic logic [D*W-1:0] m_pack();
        logic [D*W-1:0] p;
        for (int k = 0; k < D; k++) p[k*W +: W] = m_ent[k];
        return p;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < D; k++) m_ent[k] = '0;
        m_cnt = 0;
        m_win = 0;
        exp_q.delete();
    endtask

    // Drives one cycle on instance A and advances the reference window to match.
    task automatic a_cycle(input logic v, input logic [W-1:0] d, input logic ack,
                           input logic sl, input logic fl);
        a_valid = v; a_data = d; a_ack = ack; a_slide = sl; a_flush = fl;
        if (fl) begin
            for (int k = 0; k < D; k++) m_ent[k] = '0;
            m_cnt = 0;
            m_win = 0;
        end else if (!m_win) begin
            if (v) begin
                for (int k = D - 1; k > 0; k--) m_ent[k] = m_ent[k-1];
                m_ent[0] = d;
                m_cnt += C;
                if (m_cnt == D) begin
                    m_win = 1;
                    exp_q.push_back(m_pack());
                end
            end
        end else if (ack) begin
            m_cnt = (sl && S < D) ? D - S : 0;
            m_win = 0;
        end
        @(posedge clk);
        #1;
        a_valid = 0; a_ack = 0; a_slide = 0; a_flush = 0;
    endtask

    task automatic b_cycle(input logic v, input logic [C2*W-1:0] d, input logic ack,
                           input logic sl);
        b_valid = v; b_data = d; b_ack = ack; b_slide = sl;
        @(posedge clk);
        #1;
        b_valid = 0; b_ack = 0; b_slide = 0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", a_ready); end
        checks++; if (a_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_count); end
        checks++; if (a_odata !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", a_odata); end
        checks++; if (a_wv !== 1'b0) begin errors++; $display("FAIL reset_wvalid got %b exp 0", a_wv); end
        checks++; if (b_count !== '0 || b_ready !== 1'b1) begin errors++; $display("FAIL reset_b got cnt=%0d rdy=%b exp 0/1", b_count, b_ready); end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) begin
            a_cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
            checks++; if (a_count !== CW'(m_cnt)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, a_count, m_cnt); end
        end
        checks++; if (a_wv !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL fill_flags got wv=%b rdy=%b exp 1/0", a_wv, a_ready); end
        checks++; if (a_odata[0 +: W] !== 8'd10 || a_odata[9*W +: W] !== 8'd1) begin errors++; $display("FAIL fill_ends got e0=%0d e9=%0d exp 10/1", a_odata[0 +: W], a_odata[9*W +: W]); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL fill_window got no expected entry exp one queued"); end
        else begin
            exp_win = exp_q.pop_front();
            if (a_odata !== exp_win) begin errors++; $display("FAIL fill_window got %h exp %h", a_odata, exp_win); end
        end
        a_cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        checks++; if (a_odata !== m_pack() || a_count !== CW'(D)) begin errors++; $display("FAIL fill_extra_ignored got %h cnt=%0d exp %h cnt=%0d", a_odata, a_count, m_pack(), D); end
    endtask

    task automatic test_slide();
        a_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        checks++; if (a_count !== CW'(D - S) || a_ready !== 1'b1 || a_wv !== 1'b0) begin errors++; $display("FAIL slide_ack got cnt=%0d rdy=%b wv=%b exp %0d/1/0", a_count, a_ready, a_wv, D - S); end
        checks++; if (a_odata[0 +: W] !== 8'd10) begin errors++; $display("FAIL slide_retain got e0=%0d exp 10", a_odata[0 +: W]); end
        a_cycle(1'b1, 8'd11, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, 8'd12, 1'b0, 1'b0, 1'b0);
        checks++; if (a_wv !== 1'b1 || a_odata[0 +: W] !== 8'd12 || a_odata[9*W +: W] !== 8'd3) begin errors++; $display("FAIL slide_window got wv=%b e0=%0d e9=%0d exp 1/12/3", a_wv, a_odata[0 +: W], a_odata[9*W +: W]); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL slide_sb got no expected entry exp one queued"); end
        else begin
            exp_win = exp_q.pop_front();
            if (a_odata !== exp_win) begin errors++; $display("FAIL slide_sb got %h exp %h", a_odata, exp_win); end
        end
    endtask

    task automatic test_clear_ack();
        a_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (a_count !== '0 || a_ready !== 1'b1) begin errors++; $display("FAIL clear_ack got cnt=%0d rdy=%b exp 0/1", a_count, a_ready); end
        for (int i = 21; i <= 30; i++) a_cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        checks++; if (a_wv !== 1'b1 || a_odata[0 +: W] !== 8'd30 || a_odata[9*W +: W] !== 8'd21) begin errors++; $display("FAIL clear_window got wv=%b e0=%0d e9=%0d exp 1/30/21", a_wv, a_odata[0 +: W], a_odata[9*W +: W]); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL clear_sb got no expected entry exp one queued"); end
        else begin
            exp_win = exp_q.pop_front();
            if (a_odata !== exp_win) begin errors++; $display("FAIL clear_sb got %h exp %h", a_odata, exp_win); end
        end
    endtask

    task automatic test_flush();
        a_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) a_cycle(1'b1, W'(40 + i), 1'b0, 1'b0, 1'b0);
        a_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        checks++; if (a_count !== 4'd5 || a_ready !== 1'b1) begin errors++; $display("FAIL ack_in_fill got cnt=%0d rdy=%b exp 5/1", a_count, a_ready); end
        a_cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        checks++; if (a_count !== '0 || a_odata !== '0 || a_ready !== 1'b1 || a_wv !== 1'b0) begin errors++; $display("FAIL flush got cnt=%0d data=%h rdy=%b wv=%b exp 0/0/1/0", a_count, a_odata, a_ready, a_wv); end
    endtask

    task automatic test_reset_mid_window();
        for (int i = 1; i <= D; i++) a_cycle(1'b1, W'(60 + i), 1'b0, 1'b0, 1'b0);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL prereset_sb got no expected entry exp one queued"); end
        else begin
            exp_win = exp_q.pop_front();
            if (a_odata !== exp_win || a_wv !== 1'b1) begin errors++; $display("FAIL prereset_sb got %h wv=%b exp %h wv=1", a_odata, a_wv, exp_win); end
        end
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if (a_wv !== 1'b0 || a_ready !== 1'b1 || a_count !== '0 || a_odata !== '0) begin errors++; $display("FAIL async_reset got wv=%b rdy=%b cnt=%0d data=%h exp 0/1/0/0", a_wv, a_ready, a_count, a_odata); end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        a_cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        checks++; if (a_odata !== m_pack() || a_count !== 4'd1) begin errors++; $display("FAIL post_reset_push got %h cnt=%0d exp %h cnt=1", a_odata, a_count, m_pack()); end
    endtask

    task automatic test_channels2();
        expb_q.push_back({8'd1, 8'd2, 8'd3, 8'd4});
        b_cycle(1'b1, {8'd2, 8'd1}, 1'b0, 1'b0);
        checks++; if (b_count !== 3'd2 || b_wv !== 1'b0) begin errors++; $display("FAIL ch2_beat1 got cnt=%0d wv=%b exp 2/0", b_count, b_wv); end
        b_cycle(1'b1, {8'd4, 8'd3}, 1'b0, 1'b0);
        checks++;
        if (b_wv !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL ch2_flags got wv=%b rdy=%b exp 1/0", b_wv, b_ready); end
        else begin
            expb_win = expb_q.pop_front();
            if (b_odata !== expb_win) begin errors++; $display("FAIL ch2_window got %h exp %h", b_odata, expb_win); end
        end
        b_cycle(1'b0, '0, 1'b1, 1'b1);
        checks++; if (b_count !== 3'd2 || b_ready !== 1'b1) begin errors++; $display("FAIL ch2_slide got cnt=%0d rdy=%b exp 2/1", b_count, b_ready); end
        expb_q.push_back({8'd3, 8'd4, 8'd5, 8'd6});
        b_cycle(1'b1, {8'd6, 8'd5}, 1'b0, 1'b0);
        checks++;
        if (b_wv !== 1'b1) begin errors++; $display("FAIL ch2_slide_window got wv=%b exp 1", b_wv); end
        else begin
            expb_win = expb_q.pop_front();
            if (b_odata !== expb_win) begin errors++; $display("FAIL ch2_slide_data got %h exp %h", b_odata, expb_win); end
        end
    endtask

    initial begin
        a_valid = 0; a_data = '0; a_ack = 0; a_slide = 0; a_flush = 0;
        b_valid = 0; b_data = '0; b_ack = 0; b_slide = 0; b_flush = 0;
        test_reset();
        test_fill();
        test_slide();
        test_clear_ack();
        test_flush();
        test_reset_mid_window();
        test_channels2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
